// File: rtl/mul_seq_w.sv
// Radix-2 MSB-first shift-add sequential multiplier, generic width W.
// Signed operation runs on magnitudes; the sign is applied to the finished product.
module mul_seq_w #(
  parameter int W = 8
) (
  input  logic           ck,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           fin,
  output logic [2*W-1:0] o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_next;
  logic           accept, last;
  logic [W-1:0]   ma, mb, mag_a, mag_b;
  logic           neg;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, acc_next, res_next;

  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (cnt == '0) begin
        last       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
  assign mag_a    = (sgn && a[W-1]) ? -a : a;
  assign mag_b    = (sgn && b[W-1]) ? -b : b;
  assign acc_next = {acc[2*W-2:0], 1'b0} + (mb[cnt] ? {{W{1'b0}}, ma} : '0);
  assign res_next = neg ? -acc_next : acc_next;

  always_ff @(posedge ck) begin
    if (rst) begin
      ma  <= '0;
      mb  <= '0;
      neg <= 1'b0;
      cnt <= '0;
      acc <= '0;
      o   <= '0;
      fin <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (accept) begin
        ma  <= mag_a;
        mb  <= mag_b;
        neg <= sgn & (a[W-1] ^ b[W-1]);
        acc <= '0;
        cnt <= CNT_TOP;
      end else if (state == RUN) begin
        acc <= acc_next;
        cnt <= cnt - 1'b1;
        if (last) begin
          o   <= res_next;
          fin <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_w.sv
// Directed and randomized checks of mul_seq_w at W=8 and W=16.
module tb_mul_seq_w;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst;
  logic        start8, sgn8, busy8, fin8;
  logic [7:0]  a8, b8;
  logic [15:0] o8;
  logic        start16, sgn16, busy16, fin16;
  logic [15:0] a16, b16;
  logic [31:0] o16;

  int checks = 0;
  int errors = 0;

  mul_seq_w #(.W(8)) dut8 (
    .ck(ck), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .fin(fin8), .o(o8)
  );

  mul_seq_w #(.W(16)) dut16 (
    .ck(ck), .rst(rst), .start(start16), .sgn(sgn16), .a(a16), .b(b16),
    .busy(busy16), .fin(fin16), .o(o16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus8(input logic s, input logic [7:0] av, input logic [7:0] bv);
    @(negedge ck);
    start8 = 1'b1; sgn8 = s; a8 = av; b8 = bv;
    @(negedge ck);
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3; sgn8 = ~s;
  endtask

  task automatic applyStimulus16(input logic s, input logic [15:0] av, input logic [15:0] bv);
    @(negedge ck);
    start16 = 1'b1; sgn16 = s; a16 = av; b16 = bv;
    @(negedge ck);
    start16 = 1'b0; a16 = 16'hA5A5; b16 = 16'h3C3C; sgn16 = ~s;
  endtask

  task automatic waitFin8(inout int cyc);
    while (fin8 !== 1'b1 && cyc < 40) begin
      @(negedge ck);
      cyc++;
    end
  endtask

  task automatic waitFin16(inout int cyc);
    while (fin16 !== 1'b1 && cyc < 60) begin
      @(negedge ck);
      cyc++;
    end
  endtask

  task automatic runOp8(input string tag, input logic s, input logic [7:0] av,
                        input logic [7:0] bv, input logic [15:0] exp);
    int cyc;
    applyStimulus8(s, av, bv);
    checkOutput({tag, "_busy"}, 64'(busy8), 64'd1);
    cyc = 0;
    waitFin8(cyc);
    checkOutput({tag, "_lat"}, 64'(cyc), 64'd8);
    checkOutput({tag, "_o"}, 64'(o8), 64'(exp));
    checkOutput({tag, "_busyfin"}, 64'(busy8), 64'd0);
    @(negedge ck);
    checkOutput({tag, "_pulse"}, 64'(fin8), 64'd0);
    checkOutput({tag, "_hold"}, 64'(o8), 64'(exp));
  endtask

  task automatic runOp16(input string tag, input logic s, input logic [15:0] av,
                         input logic [15:0] bv, input logic [31:0] exp);
    int cyc;
    applyStimulus16(s, av, bv);
    cyc = 0;
    waitFin16(cyc);
    checkOutput({tag, "_lat"}, 64'(cyc), 64'd16);
    checkOutput({tag, "_o"}, 64'(o16), 64'(exp));
    @(negedge ck);
    checkOutput({tag, "_pulse"}, 64'(fin16), 64'd0);
  endtask

  initial begin
    int cyc;
    int fins;
    logic        s;
    logic [15:0] ra, rb;
    longint      pa, pb;

    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge ck);
    checkOutput("rst_busy8", 64'(busy8), 64'd0);
    checkOutput("rst_fin8", 64'(fin8), 64'd0);
    checkOutput("rst_o8", 64'(o8), 64'd0);
    checkOutput("rst_busy16", 64'(busy16), 64'd0);
    checkOutput("rst_fin16", 64'(fin16), 64'd0);
    checkOutput("rst_o16", 64'(o16), 64'd0);
    rst = 1'b0;

    runOp8("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01);
    runOp8("s_128x_128", 1'b1, 8'h80, 8'h80, 16'h4000);
    runOp8("s_3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    runOp8("s0x_7", 1'b1, 8'h00, 8'hF9, 16'h0000);
    runOp8("u200x3", 1'b0, 8'd200, 8'd3, 16'h0258);
    runOp8("u128x128", 1'b0, 8'h80, 8'h80, 16'h4000);
    runOp8("s127x_128", 1'b1, 8'h7F, 8'h80, 16'hC080);

    // A start during RUN must neither restart nor retime the operation
    applyStimulus8(1'b1, 8'hFD, 8'h05);
    cyc = 0;
    repeat (3) begin
      @(negedge ck);
      cyc++;
    end
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
    @(negedge ck);
    cyc++;
    start8 = 1'b0;
    checkOutput("ign_busy", 64'(busy8), 64'd1);
    waitFin8(cyc);
    checkOutput("ign_lat", 64'(cyc), 64'd8);
    checkOutput("ign_o", 64'(o8), 64'hFFF1);
    @(negedge ck);
    checkOutput("ign_idle", 64'(busy8), 64'd0);

    // Issue the next operation in the fin cycle itself
    applyStimulus8(1'b0, 8'hFF, 8'hFF);
    cyc = 0;
    waitFin8(cyc);
    checkOutput("b2b_first", 64'(o8), 64'hFE01);
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd2; b8 = 8'd3;
    @(negedge ck);
    start8 = 1'b0;
    checkOutput("b2b_nofin", 64'(fin8), 64'd0);
    checkOutput("b2b_busy", 64'(busy8), 64'd1);
    checkOutput("b2b_hold", 64'(o8), 64'hFE01);
    cyc = 0;
    waitFin8(cyc);
    checkOutput("b2b_lat", 64'(cyc), 64'd8);
    checkOutput("b2b_o", 64'(o8), 64'd6);

    // Reset mid-operation aborts it
    applyStimulus8(1'b1, 8'hF9, 8'h07);
    repeat (3) @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    checkOutput("abort_busy", 64'(busy8), 64'd0);
    checkOutput("abort_o", 64'(o8), 64'd0);
    checkOutput("abort_fin", 64'(fin8), 64'd0);
    fins = 0;
    repeat (12) begin
      @(negedge ck);
      if (fin8 === 1'b1) fins++;
    end
    checkOutput("abort_nofin", 64'(fins), 64'd0);
    runOp8("after_rst", 1'b1, 8'hFF, 8'hFF, 16'h0001);

    runOp16("u16max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    runOp16("s16min", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    runOp16("s16neg", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA);

    for (int i = 0; i < 12; i++) begin
      s  = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (s) begin
        pa = longint'($signed(ra));
        pb = longint'($signed(rb));
      end else begin
        pa = longint'(ra);
        pb = longint'(rb);
      end
      runOp16($sformatf("rnd%0d", i), s, ra, rb, 32'(pa * pb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
